ifq: RTL and testbench
======================

Name: ifq

Overview:
- Instruction fetch queue between the fetch pipeline and the decode stage (`dec`).
- Buffers fetched instruction packets (pc, instr, branch-prediction info) in a small synchronous FIFO.
- Upstream ready is a pure function of registered occupancy. This breaks the combinational ready chain from issue through decode back into fetch.
- Flushes completely on `pipe_flush`.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- pipe_flush  input  1  discard all queued and incoming entries
- ifp_ifq_pc  input  64  fetched instruction PC
- ifp_ifq_instr  input  32  fetched instruction word
- ifp_ifq_bp  input  1  predicted taken
- ifp_ifq_bp_track  input  2  predictor counter state
- ifp_ifq_bt  input  64  predicted target
- ifp_ifq_valid  input  1  packet valid
- ifp_ifq_ready  output  1  queue can accept a packet
- if_dec_pc  output  64  head PC
- if_dec_instr  output  32  head instruction
- if_dec_bp  output  1  head predicted taken
- if_dec_bp_track  output  2  head predictor state
- if_dec_bt  output  64  head predicted target
- if_dec_valid  output  1  head entry valid
- if_dec_ready  input  1  decode accepts head
- ifq_level  output  CNT_W  current occupancy, for performance counters

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high; all state updates on posedge `clk`.
- Storage: DEPTH entries of a 163-bit payload (64+32+1+2+64), with write pointer wp, read pointer rp (log2(DEPTH) bits each, wrap modulo DEPTH) and count (0..DEPTH).
- Push: push = ifp_ifq_valid && ifp_ifq_ready. Writes the payload at wp; wp increments.
- Pop: pop = if_dec_valid && if_dec_ready. rp increments.
- Count update: count += push − pop. A simultaneous push and pop leaves count unchanged.
- ifp_ifq_ready = (count != DEPTH).
  - Registered-state only; no path from if_dec_ready.
  - When full, push is refused even if a pop occurs in the same cycle.
- if_dec_valid = (count != 0).
- if_dec_* data = entry[rp] when valid, otherwise all zeros (masked, deterministic).
- Latency: no bypass. A packet pushed in cycle N is presented at the decode side in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flush priority is rst > pipe_flush > push/pop.
  - On pipe_flush: wp, rp and count are cleared to 0.
  - A push or pop in the same cycle is discarded; the push does not land.
  - Next cycle: if_dec_valid = 0 and ifp_ifq_ready = 1.
- Reset values:
  - wp = rp = count = 0.
  - Hence if_dec_valid = 0, ifp_ifq_ready = 1, ifq_level = 0, and all if_dec_* data = 0.
  - Payload storage is not reset.
  - Reset asserted mid-operation behaves exactly like a flush.
- Head stability: while if_dec_valid = 1 and if_dec_ready = 0, the head data must not change. Pushes to non-head entries are permitted.
- Full boundary: count = DEPTH implies ifp_ifq_ready = 0. Upstream must hold its packet.
- Empty boundary: count = 0 implies if_dec_valid = 0. if_dec_ready is ignored.
- ifq_level = count.

Decomposition:
- Add to defines.vh: `IFQ_PAYLOAD_W` (163) and the field bit offsets (`IFQ_PC_LSB`, `IFQ_INSTR_LSB`, `IFQ_BP_BIT`, `IFQ_BPT_LSB`, `IFQ_BT_LSB`).
- One generic sub-module `fifo_sync` (parameters WIDTH, DEPTH; ports push/pop/flush/full/empty/count). It is reusable for the later load/store queues.
- `ifq` handles payload packing/unpacking, output masking and the handshake glue.

Test Plan:
- Reset, then 4 back-to-back pushes (pc 0x1000, 0x1004, 0x1008, 0x100C) with if_dec_ready = 0:
  - ifp_ifq_ready falls to 0 after the 4th push; ifq_level = 4.
  - Head stays pc 0x1000 with its instr.
- From full, assert if_dec_ready = 1 with ifp_ifq_valid = 1 on pc 0x1010:
  - Cycle 1 pops 0x1000 and does not accept 0x1010.
  - Next cycle ready = 1 and 0x1010 is accepted.
  - Output order is 0x1004, 0x1008, 0x100C, 0x1010.
- Streaming with ready = 1 and valid = 1 on every cycle, pc incrementing by 4:
  - First if_dec_valid one cycle after the first push.
  - Then one instruction per cycle; ifq_level stays 1.
  - bp/bp_track/bt fields match their PCs.
- With 3 entries queued, assert pipe_flush together with a push of pc 0x2000:
  - Next cycle if_dec_valid = 0, ifq_level = 0, ifp_ifq_ready = 1.
  - 0x2000 never appears.
- Assert rst mid-stream with 2 entries queued:
  - Next cycle all if_dec_* data = 0, if_dec_valid = 0, ifp_ifq_ready = 1.
  - A subsequent push of pc 0x3000 appears as the first output.
- Random valid/ready with 10k packets against a scoreboard model:
  - In-order, lossless, no duplication.
  - Head data stable whenever valid = 1 and ready = 0.
  - ifp_ifq_ready never depends combinationally on if_dec_ready.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared constants for the instruction fetch queue: payload width, field offsets
// and the packing helper used on the fetch side of the queue.
package ifq_pkg;

  localparam int IFQ_PAYLOAD_W = 163;
  localparam int IFQ_BT_LSB    = 0;
  localparam int IFQ_BPT_LSB   = 64;
  localparam int IFQ_BP_BIT    = 66;
  localparam int IFQ_INSTR_LSB = 67;
  localparam int IFQ_PC_LSB    = 99;

  function automatic logic [IFQ_PAYLOAD_W-1:0] ifq_pack(
    input logic [63:0] pc,
    input logic [31:0] instr,
    input logic        bp,
    input logic [1:0]  bp_track,
    input logic [63:0] bt
  );
    ifq_pack = {pc, instr, bp, bp_track, bt};
  endfunction

endpackage

// File: rtl/ifq_if.sv
// Fetch-to-decode packet bus through the instruction fetch queue.
// Handshake: a packet moves on a side in any cycle where its valid and ready are
// both 1 at posedge clk; valid/data are held stable by the sender until accepted.
interface ifq_if;
  logic [63:0] ifp_ifq_pc;
  logic [31:0] ifp_ifq_instr;
  logic        ifp_ifq_bp;
  logic [1:0]  ifp_ifq_bp_track;
  logic [63:0] ifp_ifq_bt;
  logic        ifp_ifq_valid;
  logic        ifp_ifq_ready;

  logic [63:0] if_dec_pc;
  logic [31:0] if_dec_instr;
  logic        if_dec_bp;
  logic [1:0]  if_dec_bp_track;
  logic [63:0] if_dec_bt;
  logic        if_dec_valid;
  logic        if_dec_ready;

  modport master (
    output ifp_ifq_pc, ifp_ifq_instr, ifp_ifq_bp, ifp_ifq_bp_track, ifp_ifq_bt,
    output ifp_ifq_valid, if_dec_ready,
    input  ifp_ifq_ready,
    input  if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bp_track, if_dec_bt, if_dec_valid
  );

  modport slave (
    input  ifp_ifq_pc, ifp_ifq_instr, ifp_ifq_bp, ifp_ifq_bp_track, ifp_ifq_bt,
    input  ifp_ifq_valid, if_dec_ready,
    output ifp_ifq_ready,
    output if_dec_pc, if_dec_instr, if_dec_bp, if_dec_bp_track, if_dec_bt, if_dec_valid
  );
endinterface

// File: rtl/fifo_sync.sv
// Generic single-clock FIFO with synchronous flush; reused by the fetch queue and
// the load/store queues. Storage is not reset, only the pointers and count.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Guarded here as well so a careless caller cannot corrupt the count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue between fetch and decode. Upstream ready comes only
// from registered occupancy, breaking the decode-to-fetch ready chain.
module ifq
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_flush,
  ifq_if.slave             bus,
  output logic [CNT_W-1:0] ifq_level
);

  logic [IFQ_PAYLOAD_W-1:0] wdata;
  logic [IFQ_PAYLOAD_W-1:0] rdata;
  logic [IFQ_PAYLOAD_W-1:0] head;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  assign wdata = ifq_pack(bus.ifp_ifq_pc, bus.ifp_ifq_instr, bus.ifp_ifq_bp,
                          bus.ifp_ifq_bp_track, bus.ifp_ifq_bt);

  assign bus.ifp_ifq_ready = !full;
  assign bus.if_dec_valid  = !empty;
  assign push = bus.ifp_ifq_valid && bus.ifp_ifq_ready;
  assign pop  = bus.if_dec_valid && bus.if_dec_ready;

  fifo_sync #(
    .WIDTH (IFQ_PAYLOAD_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (pipe_flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (ifq_level)
  );

  // Empty-queue head is forced to zero so decode never sees stale storage.
  assign head = empty ? '0 : rdata;

  assign bus.if_dec_pc       = head[IFQ_PC_LSB +: 64];
  assign bus.if_dec_instr    = head[IFQ_INSTR_LSB +: 32];
  assign bus.if_dec_bp       = head[IFQ_BP_BIT];
  assign bus.if_dec_bp_track = head[IFQ_BPT_LSB +: 2];
  assign bus.if_dec_bt       = head[IFQ_BT_LSB +: 64];

endmodule

// File: tb/tb_ifq.sv
// Directed and randomised checks of the instruction fetch queue against a queue model.
module tb_ifq;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = 163;

  logic             clk;
  logic             rst;
  logic             pipe_flush;
  logic [CNT_W-1:0] ifq_level;

  ifq_if bus ();

  ifq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_flush (pipe_flush),
    .bus        (bus.slave),
    .ifq_level  (ifq_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Payload fields are derived from the pc so every field is checkable.
  function automatic logic [PW-1:0] pkt_of(input logic [63:0] pc);
    pkt_of = {pc, pc[31:0] ^ 32'hA5A5_0013, pc[2], pc[4:3], pc + 64'h40};
  endfunction

  function automatic logic [PW-1:0] head_now();
    head_now = {bus.if_dec_pc, bus.if_dec_instr, bus.if_dec_bp, bus.if_dec_bp_track, bus.if_dec_bt};
  endfunction

  function automatic logic [PW-1:0] in_now();
    in_now = {bus.ifp_ifq_pc, bus.ifp_ifq_instr, bus.ifp_ifq_bp, bus.ifp_ifq_bp_track, bus.ifp_ifq_bt};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [63:0] pc);
    logic [PW-1:0] p;
    p = pkt_of(pc);
    bus.ifp_ifq_valid    = valid;
    bus.ifp_ifq_pc       = p[162:99];
    bus.ifp_ifq_instr    = p[98:67];
    bus.ifp_ifq_bp       = p[66];
    bus.ifp_ifq_bp_track = p[65:64];
    bus.ifp_ifq_bt       = p[63:0];
  endtask

  // scoreboard: checks state against the model, then applies this cycle's handshake
  logic [PW-1:0] prev_head;
  logic          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("sb_level", 192'(ifq_level), 192'(exp_q.size()));
      check("sb_ready", 192'(bus.ifp_ifq_ready), 192'(exp_q.size() != DEPTH));
      check("sb_valid", 192'(bus.if_dec_valid), 192'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("sb_head", 192'(head_now()), 192'(exp_q[0]));
      else                   check("sb_head_zero", 192'(head_now()), 192'(0));
      if (prev_stall) check("sb_stable", 192'(head_now()), 192'(prev_head));
      prev_head  = head_now();
      prev_stall = bus.if_dec_valid && !bus.if_dec_ready && !pipe_flush;
      if (pipe_flush) begin
        exp_q.delete();
      end else begin
        if (bus.if_dec_valid && bus.if_dec_ready) begin
          n_pops++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (bus.ifp_ifq_valid && bus.ifp_ifq_ready) exp_q.push_back(in_now());
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    int pops0;
    logic have;
    logic [63:0] cur_pc;

    rst = 1'b1;
    pipe_flush = 1'b0;
    bus.if_dec_ready = 1'b0;
    drive(1'b0, 64'h0);
    tick(); tick();
    rst = 1'b0;
    check("rst_level", 192'(ifq_level), 192'(0));
    check("rst_ready", 192'(bus.ifp_ifq_ready), 192'(1));
    check("rst_valid", 192'(bus.if_dec_valid), 192'(0));
    check("rst_head", 192'(head_now()), 192'(0));

    // fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i));
      tick();
      check("fill_level", 192'(ifq_level), 192'(i + 1));
    end
    drive(1'b0, 64'h0);
    check("full_ready", 192'(bus.ifp_ifq_ready), 192'(0));
    check("full_head_pc", 192'(bus.if_dec_pc), 192'(64'h1000));
    check("full_head_instr", 192'(bus.if_dec_instr), 192'(32'hA5A5_1013));

    // pop from full while upstream offers 0x1010
    drive(1'b1, 64'h1010);
    bus.if_dec_ready = 1'b1;
    #1;
    check("ready_no_comb", 192'(bus.ifp_ifq_ready), 192'(0));
    tick();
    check("pop_full_level", 192'(ifq_level), 192'(3));
    check("pop_full_head", 192'(bus.if_dec_pc), 192'(64'h1004));
    check("pop_full_ready", 192'(bus.ifp_ifq_ready), 192'(1));
    tick();
    drive(1'b0, 64'h0);
    check("order_1008", 192'(bus.if_dec_pc), 192'(64'h1008));
    tick();
    check("order_100c", 192'(bus.if_dec_pc), 192'(64'h100C));
    tick();
    check("order_1010", 192'(bus.if_dec_pc), 192'(64'h1010));
    tick();
    check("drained", 192'(bus.if_dec_valid), 192'(0));

    // streaming: one in, one out per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h4000 + 64'(4 * i));
      if (i == 0) check("stream_first_invalid", 192'(bus.if_dec_valid), 192'(0));
      tick();
      check("stream_level", 192'(ifq_level), 192'(1));
      check("stream_head", 192'(head_now()), 192'(pkt_of(64'h4000 + 64'(4 * i))));
    end
    drive(1'b0, 64'h0);
    tick();
    check("stream_end_level", 192'(ifq_level), 192'(0));

    // flush with 3 queued and a same-cycle push of 0x2000
    bus.if_dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h1800 + 64'(4 * i));
      tick();
    end
    check("pre_flush_level", 192'(ifq_level), 192'(3));
    drive(1'b1, 64'h2000);
    pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    drive(1'b0, 64'h0);
    check("flush_valid", 192'(bus.if_dec_valid), 192'(0));
    check("flush_level", 192'(ifq_level), 192'(0));
    check("flush_ready", 192'(bus.ifp_ifq_ready), 192'(1));
    bus.if_dec_ready = 1'b1;
    tick(); tick();
    check("flush_no_2000", 192'(bus.if_dec_valid), 192'(0));

    // reset mid-stream with 2 queued
    bus.if_dec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h2800 + 64'(4 * i));
      tick();
    end
    drive(1'b0, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_head", 192'(head_now()), 192'(0));
    check("midrst_valid", 192'(bus.if_dec_valid), 192'(0));
    check("midrst_ready", 192'(bus.ifp_ifq_ready), 192'(1));
    drive(1'b1, 64'h3000);
    tick();
    drive(1'b0, 64'h0);
    check("post_rst_first", 192'(head_now()), 192'(pkt_of(64'h3000)));
    bus.if_dec_ready = 1'b1;
    tick();

    // random valid/ready, 10k packets
    pops0  = n_pops;
    sent   = 0;
    cyc    = 0;
    have   = 1'b0;
    cur_pc = 64'h8000;
    while (sent < 10000 && cyc < 60000) begin
      if (!have) have = ($urandom_range(0, 99) < 70);
      drive(have, cur_pc);
      bus.if_dec_ready = ($urandom_range(0, 99) < 65);
      if (have && bus.ifp_ifq_ready) begin
        sent++;
        cur_pc = cur_pc + 64'd4;
        have = 1'b0;
      end
      tick();
      cyc++;
    end
    drive(1'b0, 64'h0);
    bus.if_dec_ready = 1'b1;
    cyc = 0;
    while (bus.if_dec_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("rand_sent", 192'(sent), 192'(10000));
    check("rand_popped", 192'(n_pops - pops0), 192'(10000));
    check("rand_empty", 192'(ifq_level), 192'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
